// File: rtl/reg_bank_uart_tx_if.sv
// Purpose: signal bundle between a register-bank owner and the UART frame transmitter.
// Latency: none; plain wires.
// Backpressure: none. start is a level request that the transmitter samples only while idle.
// Ports: start (frame request), bank_dat (bank to snapshot), txd (UART line),
//        busy (frame in progress), done (end-of-frame pulse), frame_ctr (completed frames).
interface reg_bank_uart_tx_if #(
    parameter int C_BYTES = 128
);
    logic                 start;
    logic [8*C_BYTES-1:0] bank_dat;
    logic                 txd;
    logic                 busy;
    logic                 done;
    logic [7:0]           frame_ctr;

    modport master (
        output start,
        output bank_dat,
        input  txd,
        input  busy,
        input  done,
        input  frame_ctr
    );

    modport slave (
        input  start,
        input  bank_dat,
        output txd,
        output busy,
        output done,
        output frame_ctr
    );
endinterface

// File: rtl/reg_bank_uart_tx.sv
// Purpose: sends a snapshot of a byte bank as a UART frame: 55 AA, data bytes, then the data checksum.
// Latency: the start bit appears one cycle after accept; the frame lasts (C_BYTES+3)*10*C_DIV cycles; done follows one cycle later.
// Backpressure: none. A start request while busy is dropped, not queued. C_AUTO=1 re-arms in the done cycle.
// Ports: clk, rst (async, active high); bus.slave carries start, bank_dat, txd, busy, done and frame_ctr.
module reg_bank_uart_tx #(
    parameter int C_F_CK  = 135_000_000,
    parameter int C_BAUD  = 115_200,
    parameter int C_BYTES = 128,
    parameter bit C_AUTO  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    reg_bank_uart_tx_if.slave bus
);
    localparam int C_DIV = C_F_CK / C_BAUD;
    localparam int DIV_W = $clog2(C_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_DIV - 1);
    // Byte index 0/1 = header, 2..C_BYTES+1 = data, C_BYTES+2 = checksum.
    localparam logic [8:0] IDX_CSUM = 9'(C_BYTES + 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [8:0]           idx_q, idx_d;
    logic [8*C_BYTES-1:0] snap_q, snap_d;
    logic [7:0]           csum_q, csum_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7:0]           ctr_q, ctr_d;

    logic                 bit_end;
    logic [2:0]           nxt_bit;
    logic [7:0]           cur_byte;

    assign bit_end = (div_q == DIV_LAST);
    assign nxt_bit = bit_q + 3'd1;

    // The snapshot shifts down one byte after each data byte, so the byte
    // being sent always sits in the low lane and no wide mux is needed.
    always_comb begin
        cur_byte = snap_q[7:0];
        if (idx_q == 9'd0) begin
            cur_byte = 8'h55;
        end else if (idx_q == 9'd1) begin
            cur_byte = 8'hAA;
        end else if (idx_q == IDX_CSUM) begin
            cur_byte = csum_q;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        csum_d  = csum_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ctr_d   = ctr_q;

        // The bit-time counter reloads exactly at each boundary, so bit timing does not drift.
        if (state_q != S_IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start || C_AUTO) begin
                    state_d = S_START;
                    div_d   = '0;
                    bit_d   = '0;
                    idx_d   = '0;
                    snap_d  = bus.bank_dat;
                    csum_d  = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = nxt_bit;
                        txd_d = cur_byte[nxt_bit];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_CSUM) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ctr_d   = ctr_q + 8'd1;
                        txd_d   = 1'b1;
                    end else begin
                        // The checksum accumulates as data bytes retire, so it is complete
                        // by the time the checksum byte is selected.
                        if (idx_q >= 9'd2) begin
                            csum_d = csum_q + snap_q[7:0];
                            snap_d = snap_q >> 8;
                        end
                        idx_d   = idx_q + 9'd1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            csum_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            csum_q  <= csum_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctr_q   <= ctr_d;
        end
    end

    assign bus.txd       = txd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_ctr = ctr_q;
endmodule

// File: tb/tb_reg_bank_uart_tx.sv
module tb_reg_bank_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_auto;
    logic rst_wrap;

    int total = 0;
    int bad   = 0;
    int exp_ctr = 0;

    reg_bank_uart_tx_if #(.C_BYTES(4)) bus ();
    reg_bank_uart_tx_if #(.C_BYTES(4)) bus_auto ();
    reg_bank_uart_tx_if #(.C_BYTES(1)) bus_wrap ();

    reg_bank_uart_tx #(.C_F_CK(16), .C_BAUD(1), .C_BYTES(4), .C_AUTO(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_bank_uart_tx #(.C_F_CK(16), .C_BAUD(1), .C_BYTES(4), .C_AUTO(1'b1)) u_auto (
        .clk (clk),
        .rst (rst_auto),
        .bus (bus_auto)
    );

    reg_bank_uart_tx #(.C_F_CK(2), .C_BAUD(1), .C_BYTES(1), .C_AUTO(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst_wrap),
        .bus (bus_wrap)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at the first cycle of a frame (one cycle after accept). Checks every
    // cycle of the line against the expected bit stream, decodes mid-bit samples,
    // then checks the done cycle and the frame counter.
    task automatic frame_check(input logic [31:0] data, input logic [7:0] csum, input string tag);
        logic [7:0] eb  [0:6];
        logic [7:0] got [0:6];
        int tim_err;
        int busy_err;
        int b;
        int p;
        logic e;
        tim_err  = 0;
        busy_err = 0;
        eb[0] = 8'h55;
        eb[1] = 8'hAA;
        for (int k = 0; k < 4; k++) eb[k+2] = data[8*k +: 8];
        eb[6] = csum;
        for (int i = 0; i < 7; i++) got[i] = 8'h00;
        for (int c = 0; c < 1120; c++) begin
            b = c / 160;
            p = (c % 160) / 16;
            e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : eb[b][p-1];
            if (bus.txd !== e) tim_err++;
            if (bus.busy !== 1'b1) busy_err++;
            if ((c % 16) == 8 && p >= 1 && p <= 8) got[b][p-1] = bus.txd;
            tick(1);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== eb[i]) begin
                bad++;
                $display("FAIL %s byte%0d: got %h want %h", tag, i, got[i], eb[i]);
            end
        end
        total++;
        if (tim_err != 0) begin
            bad++;
            $display("FAIL %s bit_timing: %0d wrong line cycles, want 0", tag, tim_err);
        end
        total++;
        if (busy_err != 0) begin
            bad++;
            $display("FAIL %s busy_during_frame: %0d low cycles, want 0", tag, busy_err);
        end
        exp_ctr = (exp_ctr + 1) % 256;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.frame_ctr !== 8'(exp_ctr)) begin
            bad++;
            $display("FAIL %s end_cycle: busy=%b done=%b ctr=%0d want busy=0 done=1 ctr=%0d",
                     tag, bus.busy, bus.done, bus.frame_ctr, exp_ctr);
        end
        tick(1);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width: done=%b busy=%b want 0 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic send(input logic [31:0] data);
        bus.bank_dat = data;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        total++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_ctr !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: txd=%b busy=%b done=%b ctr=%0d want 1 0 0 0",
                     bus.txd, bus.busy, bus.done, bus.frame_ctr);
        end
        rst = 1'b0;
        tick(5);
        total++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: txd=%b busy=%b want 1 0", bus.txd, bus.busy);
        end
    endtask

    task automatic test_basic;
        send(32'h04030201);
        frame_check(32'h04030201, 8'h0A, "basic");
    endtask

    task automatic test_checksum_wrap;
        tick(3);
        send(32'hFFFFFFFF);
        frame_check(32'hFFFFFFFF, 8'hFC, "csum_wrap");
    endtask

    task automatic test_snapshot_ignore;
        int noise;
        noise = 0;
        tick(3);
        send(32'h04030201);
        fork
            frame_check(32'h04030201, 8'h0A, "snapshot");
            begin
                tick(300);
                bus.bank_dat = 32'h0;
                bus.start = 1'b1;
                tick(1);
                bus.start = 1'b0;
            end
        join
        for (int c = 0; c < 500; c++) begin
            if (bus.busy !== 1'b0 || bus.txd !== 1'b1) noise++;
            tick(1);
        end
        total++;
        if (noise != 0) begin
            bad++;
            $display("FAIL start_ignored: %0d active cycles after frame, want 0", noise);
        end
    endtask

    task automatic test_reset_mid_frame;
        int noise;
        noise = 0;
        send(32'h04030201);
        // Frame cycle 712 = byte 4 (data byte 2 = 0x03), data bit 3 which is 0.
        tick(712);
        total++;
        if (bus.txd !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_line: txd=%b busy=%b want 0 1", bus.txd, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_ctr !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: txd=%b busy=%b done=%b ctr=%0d want 1 0 0 0",
                     bus.txd, bus.busy, bus.done, bus.frame_ctr);
        end
        tick(3);
        rst = 1'b0;
        exp_ctr = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.busy !== 1'b0 || bus.txd !== 1'b1 || bus.done !== 1'b0) noise++;
            tick(1);
        end
        total++;
        if (noise != 0) begin
            bad++;
            $display("FAIL idle_after_reset: %0d active cycles, want 0", noise);
        end
        send(32'h04030201);
        frame_check(32'h04030201, 8'h0A, "after_reset");
    endtask

    task automatic test_auto;
        int w;
        int len;
        rst_auto = 1'b0;
        w = 0;
        while (bus_auto.busy !== 1'b1 && w < 10) begin
            tick(1);
            w++;
        end
        total++;
        if (w != 1 || bus_auto.txd !== 1'b0) begin
            bad++;
            $display("FAIL auto_first_start: latency=%0d txd=%b want 1 0", w, bus_auto.txd);
        end
        for (int f = 1; f <= 3; f++) begin
            len = 0;
            while (bus_auto.busy === 1'b1 && len < 2000) begin
                len++;
                tick(1);
            end
            total++;
            if (len != 1120) begin
                bad++;
                $display("FAIL auto_len%0d: busy %0d cycles want 1120", f, len);
            end
            total++;
            if (bus_auto.done !== 1'b1 || bus_auto.frame_ctr !== 8'(f) || bus_auto.txd !== 1'b1) begin
                bad++;
                $display("FAIL auto_done%0d: done=%b ctr=%0d txd=%b want 1 %0d 1",
                         f, bus_auto.done, bus_auto.frame_ctr, bus_auto.txd, f);
            end
            tick(1);
            total++;
            if (bus_auto.busy !== 1'b1 || bus_auto.txd !== 1'b0 || bus_auto.done !== 1'b0) begin
                bad++;
                $display("FAIL auto_restart%0d: busy=%b txd=%b done=%b want 1 0 0",
                         f, bus_auto.busy, bus_auto.txd, bus_auto.done);
            end
        end
        rst_auto = 1'b1;
    endtask

    task automatic test_counter_wrap;
        int dones;
        int cyc;
        int last;
        int gap_err;
        logic [7:0] ctr255;
        logic [7:0] ctr256;
        dones   = 0;
        cyc     = 0;
        last    = 0;
        gap_err = 0;
        ctr255  = 8'h00;
        ctr256  = 8'hEE;
        bus_wrap.start = 1'b1;
        rst_wrap = 1'b0;
        // Each frame: 4 bytes * 10 bits * 2 cycles busy, plus the done cycle.
        while (dones < 256 && cyc < 30000) begin
            tick(1);
            cyc++;
            if (bus_wrap.done === 1'b1) begin
                dones++;
                if (cyc - last != 81) gap_err++;
                last = cyc;
                if (dones == 255) ctr255 = bus_wrap.frame_ctr;
                if (dones == 256) ctr256 = bus_wrap.frame_ctr;
            end
        end
        bus_wrap.start = 1'b0;
        total++;
        if (dones != 256) begin
            bad++;
            $display("FAIL wrap_frames: %0d done pulses want 256", dones);
        end
        total++;
        if (gap_err != 0) begin
            bad++;
            $display("FAIL wrap_period: %0d frames not 81 cycles apart, want 0", gap_err);
        end
        total++;
        if (ctr255 !== 8'd255) begin
            bad++;
            $display("FAIL wrap_ctr255: got %0d want 255", ctr255);
        end
        total++;
        if (ctr256 !== 8'd0) begin
            bad++;
            $display("FAIL wrap_ctr0: got %0d want 0", ctr256);
        end
        rst_wrap = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        rst_auto = 1'b1;
        rst_wrap = 1'b1;
        bus.start          = 1'b0;
        bus.bank_dat       = '0;
        bus_auto.start     = 1'b0;
        bus_auto.bank_dat  = 32'h04030201;
        bus_wrap.start     = 1'b0;
        bus_wrap.bank_dat  = 8'h5A;

        test_reset();
        test_basic();
        test_checksum_wrap();
        test_snapshot_ignore();
        test_reset_mid_frame();
        test_auto();
        test_counter_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_uart_tx.md
# reg_bank_uart_tx

Streams a snapshot of a byte-organised register bank out of the board on a single UART TX pin: sync header, N data bytes, checksum. It is the transmit-side counterpart of the JTAG register bridge. The same DATss-style bank the top feeds to the JTAG registers can also be pushed to a host over a spare header pin (e.g. J2_33) without a JTAG cable. It sits in the board top on the system clock, next to the JTAG register block.

## Interface
- C_F_CK, 135_000_000, clock frequency in Hz
- C_BAUD, 115_200, line rate; bit time C_DIV = C_F_CK / C_BAUD cycles (integer truncation, C_DIV ≥ 2)
- C_BYTES, 128, number of data bytes in the bank (1..255)
- C_AUTO, 0, 1 = free-running: a new frame starts automatically after each frame
- CK_i  in  1  system clock; all logic on rising edge
- ARST_i  in  1  asynchronous, active-high reset
- START_i  in  1  frame request, sampled only when idle
- DATss_i  in  8*C_BYTES  register bank; byte k = DATss_i[8*k +: 8]
- TXD_o  out  1  UART line, idle high
- BUSY_o  out  1  frame in progress
- DONE_o  out  1  one-cycle pulse at frame end
- FRAME_CTR_o  out  8  completed-frame count, wraps 255→0

## Operation
- Frame byte order: 0x55, 0xAA, byte 0 … byte C_BYTES-1, then checksum.
- Checksum = sum of the data bytes mod 256. The header bytes are excluded.
- Each byte is sent 8N1: start bit 0, data LSB first, stop bit 1. There is no idle gap between bytes.
- States:
  - IDLE: TXD_o=1, BUSY_o=0.
  - START: 1 bit time, TXD_o=0.
  - DATA: 8 bit times.
  - STOP: 1 bit time, TXD_o=1. Then move to START of the next byte, or to IDLE after the checksum byte.
- Byte index counter runs 0..C_BYTES+2 and selects header / snapshot byte / checksum.
- Snapshot:
  - DATss_i is copied into an internal register in the accept cycle.
  - The checksum is computed over the snapshot.
  - Changes on DATss_i during a frame do not affect that frame.
- Accept condition: state IDLE and (START_i=1 or C_AUTO=1).
- START_i asserted while BUSY_o=1 is ignored, not queued.
- Reset values: TXD_o=1, BUSY_o=0, DONE_o=0, FRAME_CTR_o=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame:
  - TXD_o returns to 1 immediately (asynchronously).
  - The frame is abandoned. No DONE_o pulse and no FRAME_CTR_o increment.
  - After release, nothing is transmitted until the next accept.

## Timing
- Accept in cycle t:
  - BUSY_o=1 and TXD_o=0 from cycle t+1. TXD_o is registered, so there is no combinational path from START_i.
- Every bit lasts exactly C_DIV cycles. The bit-time counter reloads at each bit boundary with no drift.
- Frame length is (C_BYTES+3)·10·C_DIV cycles, measured from t+1 to the end of the checksum stop bit.
- Cycle after the last stop bit:
  - BUSY_o=0 and DONE_o=1 for exactly one cycle.
  - FRAME_CTR_o increments in that same cycle.
- With C_AUTO=1 the DONE_o cycle is the idle accept cycle, so the next start bit begins one cycle after DONE_o. The line sees exactly 1 idle cycle between frames.
- START_i held high with C_AUTO=0 behaves the same way as C_AUTO=1.

## Test plan
- Basic frame:
  - Setup: C_F_CK=16, C_BAUD=1 (C_DIV=16), C_BYTES=4, DATss_i=32'h04030201, one START_i pulse.
  - Required: decoded bytes 55 AA 01 02 03 04 0A.
  - Required: BUSY_o high for exactly 7·10·16=1120 cycles, then DONE_o pulses once and FRAME_CTR_o=1.
- Checksum wrap:
  - Setup: DATss_i=32'hFFFFFFFF.
  - Required: checksum byte 0xFC.
  - Required: every bit edge is exactly 16 cycles apart, with start bit low and stop bit high.
- Snapshot and ignore:
  - Stimulus: change DATss_i to 32'h0 and pulse START_i while mid-frame.
  - Required: the frame still carries 01 02 03 04 / 0A.
  - Required: no second frame follows.
- Auto mode:
  - Setup: C_AUTO=1, no START_i, run 3 frames.
  - Required: 1 idle cycle between frames.
  - Required: FRAME_CTR_o steps 1, 2, 3, with DONE_o pulsing once per frame.
- Reset mid-frame:
  - Stimulus: assert ARST_i during data byte 2.
  - Required: TXD_o=1 in the same cycle, and BUSY_o, DONE_o and FRAME_CTR_o all 0.
  - Required: after release, line idle until START_i, then a complete correct frame.
- Counter wrap:
  - Stimulus: 256 frames.
  - Required: FRAME_CTR_o returns to 0.
